ddr_wr_stim_gen: RTL

- Traffic generator for the DDR bandwidth test.
- Sits directly upstream of the AXI write master and drives its AXIS slave input.
- Each beat carries {address, data} packed as tdata[DATA_WIDTH+ADDR_WIDTH-1:DATA_WIDTH] = address and tdata[DATA_WIDTH-1:0] = data.
- Emits a programmed number of beats at a programmed start address and stride, with a checkable data pattern.
- Measures the cycle count of the run for bandwidth computation.

---
 rtl/ddr_wr_stim_gen.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ddr_wr_stim_gen.sv
// AXI-Stream write-traffic generator for the DDR bandwidth test.
// Emits NWORDS {addr, data} beats from a start address with a fixed stride
// and counts the cycles spanned by the accepted beats.
module ddr_wr_stim_gen #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 START_REG,
  input  logic [31:0]                          ADDR_REG,
  input  logic [31:0]                          STRIDE_REG,
  input  logic [31:0]                          NWORDS_REG,
  input  logic                                 PATTERN_REG,
  input  logic [31:0]                          SEED_REG,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]              m_axis_tstrb,
  output logic                                 m_axis_tlast,
  output logic                                 BUSY_REG,
  output logic                                 DONE_REG,
  output logic [31:0]                          WCOUNT_REG,
  output logic [31:0]                          CYCLES_REG
);

  localparam int unsigned REP = DATA_WIDTH / ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    DONE_ST = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic                            start_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]           stride_q, stride_d;
  logic [ADDR_WIDTH-1:0]           seed_q, seed_d;
  logic [31:0]                     nwords_q, nwords_d;
  logic [31:0]                     idx_q, idx_d;
  logic                            pat_q, pat_d;
  logic                            started_q, started_d;
  logic                            tvalid_d, tlast_d, busy_d, done_d;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] tdata_d;
  logic [31:0]                     wcount_d, cycles_d;
  logic [ADDR_WIDTH-1:0]           next_addr;
  logic [31:0]                     next_idx;
  logic                            start_edge;
  logic                            beat_acc;

  // Data word for one beat: running index, or address^seed replicated
  function automatic logic [DATA_WIDTH-1:0] beat_data(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [31:0]           idx,
    input logic                  pat,
    input logic [ADDR_WIDTH-1:0] seed
  );
    if (pat) return {REP{addr ^ seed}};
    return DATA_WIDTH'(idx);
  endfunction

  assign start_edge   = START_REG & ~start_d;
  assign beat_acc     = m_axis_tvalid & m_axis_tready;
  assign m_axis_tstrb = '1;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    seed_d    = seed_q;
    nwords_d  = nwords_q;
    idx_d     = idx_q;
    pat_d     = pat_q;
    started_d = started_q;
    tvalid_d  = m_axis_tvalid;
    tlast_d   = m_axis_tlast;
    tdata_d   = m_axis_tdata;
    busy_d    = BUSY_REG;
    done_d    = DONE_REG;
    wcount_d  = WCOUNT_REG;
    cycles_d  = CYCLES_REG;
    next_addr = addr_q + stride_q;
    next_idx  = idx_q + 32'd1;

    case (state_q)
      IDLE, DONE_ST: begin
        if (start_edge) begin
          state_d   = LOAD;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          wcount_d  = 32'd0;
          cycles_d  = 32'd0;
          started_d = 1'b0;
        end
      end
      LOAD: begin
        addr_d   = ADDR_WIDTH'(ADDR_REG);
        stride_d = ADDR_WIDTH'(STRIDE_REG);
        seed_d   = ADDR_WIDTH'(SEED_REG);
        nwords_d = NWORDS_REG;
        pat_d    = PATTERN_REG;
        idx_d    = 32'd0;
        if (NWORDS_REG == 32'd0) begin
          state_d = DONE_ST;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d  = RUN;
          tvalid_d = 1'b1;
          tlast_d  = (NWORDS_REG == 32'd1);
          tdata_d  = {ADDR_WIDTH'(ADDR_REG),
                      beat_data(ADDR_WIDTH'(ADDR_REG), 32'd0, PATTERN_REG,
                                ADDR_WIDTH'(SEED_REG))};
        end
      end
      RUN: begin
        if (beat_acc || started_q) cycles_d = CYCLES_REG + 32'd1;
        if (beat_acc) begin
          started_d = 1'b1;
          wcount_d  = WCOUNT_REG + 32'd1;
          if (idx_q == nwords_q - 32'd1) begin
            state_d  = DONE_ST;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            addr_d  = next_addr;
            idx_d   = next_idx;
            tlast_d = (next_idx == nwords_q - 32'd1);
            tdata_d = {next_addr, beat_data(next_addr, next_idx, pat_q, seed_q)};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_d       <= 1'b0;
      addr_q        <= '0;
      stride_q      <= '0;
      seed_q        <= '0;
      nwords_q      <= 32'd0;
      idx_q         <= 32'd0;
      pat_q         <= 1'b0;
      started_q     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      BUSY_REG      <= 1'b0;
      DONE_REG      <= 1'b0;
      WCOUNT_REG    <= 32'd0;
      CYCLES_REG    <= 32'd0;
    end else begin
      start_d       <= START_REG;
      addr_q        <= addr_d;
      stride_q      <= stride_d;
      seed_q        <= seed_d;
      nwords_q      <= nwords_d;
      idx_q         <= idx_d;
      pat_q         <= pat_d;
      started_q     <= started_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tlast  <= tlast_d;
      m_axis_tdata  <= tdata_d;
      BUSY_REG      <= busy_d;
      DONE_REG      <= done_d;
      WCOUNT_REG    <= wcount_d;
      CYCLES_REG    <= cycles_d;
    end
  end

endmodule
